prometheus_fx3_sf_out_stage: RTL and testbench

Output stage between the FX3 slave-FIFO test-pattern generators (stream, partial, ZLP) and the GPIF II pins. It samples and registers the raw FX3 flags for the generators and grants one generator at a time via a mode-select handshake. Mode changes go through a guarded drain. The selected generator's write strobe, packet-end and data are registered onto the pins. Write and packet statistics and a sticky protocol-error flag are maintained.

---
 rtl/prometheus_fx3_sf_out_stage.sv | 195 +++++++++++++++++++
 tb/tb_prometheus_fx3_sf_out_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/prometheus_fx3_sf_out_stage.sv
// FX3 slave-FIFO output stage: registers the raw FX3 flags for the pattern
// generators, grants one generator at a time, drains for a guard interval on
// every mode change, and drives the selected generator onto the GPIF II pins.
// Also keeps write and packet statistics and a sticky write-while-not-ready flag.
module prometheus_fx3_sf_out_stage #(
    parameter int         GUARD_CYCLES = 16,
    parameter logic [1:0] FIFO_ADDR    = 2'b00
) (
    input  logic        clk_100,
    input  logic        rst_n,
    input  logic [1:0]  i_mode_req,
    input  logic        i_flaga,
    input  logic        i_flagb,
    input  logic        i_we_n_stream,
    input  logic        i_we_n_partial,
    input  logic        i_we_n_zlp,
    input  logic        i_pkt_end_n_stream,
    input  logic        i_pkt_end_n_partial,
    input  logic        i_pkt_end_n_zlp,
    input  logic [31:0] i_data_stream,
    input  logic [31:0] i_data_partial,
    input  logic        i_clr_stats,
    output logic        o_gpif_in_ch0_rdy_d,
    output logic        o_gpif_out_ch0_rdy_d,
    output logic        o_stream_sel,
    output logic        o_partial_sel,
    output logic        o_zlp_sel,
    output logic        o_slcs_n,
    output logic        o_slwr_n,
    output logic        o_slrd_n,
    output logic        o_sloe_n,
    output logic        o_pktend_n,
    output logic [1:0]  o_fifo_addr,
    output logic [31:0] o_data,
    output logic        o_data_oe,
    output logic [31:0] o_word_cnt,
    output logic [15:0] o_pkt_cnt,
    output logic        o_err_wr_not_rdy
);

    localparam int GW = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

    state_t         state, state_nxt;
    logic [1:0]     active_mode, active_mode_nxt;
    logic [GW-1:0]  guard_cnt, guard_cnt_nxt;
    logic [2:0]     grant_nxt;
    logic           mux_we_n, mux_pe_n;
    logic [31:0]    mux_data;

    // Write-only block: read strobes are parked, address is a constant.
    assign o_slrd_n    = 1'b1;
    assign o_sloe_n    = 1'b1;
    assign o_fifo_addr = FIFO_ADDR;

    // Flag sampling: one register stage in every state.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            o_gpif_in_ch0_rdy_d  <= 1'b0;
            o_gpif_out_ch0_rdy_d <= 1'b0;
        end else begin
            o_gpif_in_ch0_rdy_d  <= i_flaga;
            o_gpif_out_ch0_rdy_d <= i_flagb;
        end
    end

    // Mode FSM state, latched mode and drain guard counter.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            active_mode <= 2'd0;
            guard_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            active_mode <= active_mode_nxt;
            guard_cnt   <= guard_cnt_nxt;
        end
    end

    // Next-state logic; the grant is computed here so it drops on the same
    // edge the FSM leaves ACTIVE and rises one cycle after entering it.
    always_comb begin
        state_nxt       = state;
        active_mode_nxt = active_mode;
        guard_cnt_nxt   = guard_cnt;
        grant_nxt       = 3'b000;
        case (state)
            S_IDLE: begin
                if (i_mode_req != 2'd0) begin
                    state_nxt       = S_ACTIVE;
                    active_mode_nxt = i_mode_req;
                end
            end
            S_ACTIVE: begin
                if (i_mode_req != active_mode) begin
                    state_nxt     = S_DRAIN;
                    guard_cnt_nxt = '0;
                end else begin
                    case (active_mode)
                        2'd1:    grant_nxt = 3'b001;
                        2'd2:    grant_nxt = 3'b010;
                        2'd3:    grant_nxt = 3'b100;
                        default: grant_nxt = 3'b000;
                    endcase
                end
            end
            S_DRAIN: begin
                guard_cnt_nxt = guard_cnt + 1'b1;
                if (guard_cnt == GW'(GUARD_CYCLES - 1)) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant outputs, one-hot {zlp, partial, stream}.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            o_stream_sel  <= 1'b0;
            o_partial_sel <= 1'b0;
            o_zlp_sel     <= 1'b0;
        end else begin
            o_stream_sel  <= grant_nxt[0];
            o_partial_sel <= grant_nxt[1];
            o_zlp_sel     <= grant_nxt[2];
        end
    end

    // Source select for the pins; unselected generators never get through.
    always_comb begin
        mux_we_n = 1'b1;
        mux_pe_n = 1'b1;
        mux_data = 32'd0;
        case (active_mode)
            2'd1: begin
                mux_we_n = i_we_n_stream;
                mux_pe_n = i_pkt_end_n_stream;
                mux_data = i_data_stream;
            end
            2'd2: begin
                mux_we_n = i_we_n_partial;
                mux_pe_n = i_pkt_end_n_partial;
                mux_data = i_data_partial;
            end
            2'd3: begin
                mux_we_n = i_we_n_zlp;
                mux_pe_n = i_pkt_end_n_zlp;
                mux_data = 32'd0;
            end
            default: ;
        endcase
    end

    // Registered pin drive; outside ACTIVE strobes park high and data holds.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            o_slcs_n   <= 1'b1;
            o_slwr_n   <= 1'b1;
            o_pktend_n <= 1'b1;
            o_data     <= 32'd0;
            o_data_oe  <= 1'b0;
        end else if (state == S_ACTIVE) begin
            o_slcs_n   <= 1'b0;
            o_slwr_n   <= mux_we_n;
            o_pktend_n <= mux_pe_n;
            o_data     <= mux_data;
            o_data_oe  <= 1'b1;
        end else begin
            o_slcs_n   <= 1'b1;
            o_slwr_n   <= 1'b1;
            o_pktend_n <= 1'b1;
            o_data_oe  <= 1'b0;
        end
    end

    // Statistics from the pin-side strobes; clear wins over count and error set.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            o_word_cnt       <= 32'd0;
            o_pkt_cnt        <= 16'd0;
            o_err_wr_not_rdy <= 1'b0;
        end else if (i_clr_stats) begin
            o_word_cnt       <= 32'd0;
            o_pkt_cnt        <= 16'd0;
            o_err_wr_not_rdy <= 1'b0;
        end else begin
            if (!o_slwr_n)   o_word_cnt <= o_word_cnt + 32'd1;
            if (!o_pktend_n) o_pkt_cnt  <= o_pkt_cnt + 16'd1;
            if (!o_slwr_n && !o_gpif_in_ch0_rdy_d) o_err_wr_not_rdy <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prometheus_fx3_sf_out_stage.sv
// Bench for prometheus_fx3_sf_out_stage: directed vector table, hand-written
// drain / error / reset sequences, then random traffic against a reference model.
module tb_prometheus_fx3_sf_out_stage;

    localparam int GUARD = 16;

    logic        clk_100 = 1'b0;
    logic        rst_n;
    logic [1:0]  i_mode_req;
    logic        i_flaga, i_flagb;
    logic        i_we_n_stream, i_we_n_partial, i_we_n_zlp;
    logic        i_pkt_end_n_stream, i_pkt_end_n_partial, i_pkt_end_n_zlp;
    logic [31:0] i_data_stream, i_data_partial;
    logic        i_clr_stats;
    logic        o_gpif_in_ch0_rdy_d, o_gpif_out_ch0_rdy_d;
    logic        o_stream_sel, o_partial_sel, o_zlp_sel;
    logic        o_slcs_n, o_slwr_n, o_slrd_n, o_sloe_n, o_pktend_n;
    logic [1:0]  o_fifo_addr;
    logic [31:0] o_data;
    logic        o_data_oe;
    logic [31:0] o_word_cnt;
    logic [15:0] o_pkt_cnt;
    logic        o_err_wr_not_rdy;

    int vectors = 0;
    int errors  = 0;

    always #5 clk_100 = ~clk_100;

    prometheus_fx3_sf_out_stage #(.GUARD_CYCLES(GUARD), .FIFO_ADDR(2'b00)) dut (
        .clk_100(clk_100), .rst_n(rst_n), .i_mode_req(i_mode_req),
        .i_flaga(i_flaga), .i_flagb(i_flagb),
        .i_we_n_stream(i_we_n_stream), .i_we_n_partial(i_we_n_partial), .i_we_n_zlp(i_we_n_zlp),
        .i_pkt_end_n_stream(i_pkt_end_n_stream), .i_pkt_end_n_partial(i_pkt_end_n_partial),
        .i_pkt_end_n_zlp(i_pkt_end_n_zlp),
        .i_data_stream(i_data_stream), .i_data_partial(i_data_partial),
        .i_clr_stats(i_clr_stats),
        .o_gpif_in_ch0_rdy_d(o_gpif_in_ch0_rdy_d), .o_gpif_out_ch0_rdy_d(o_gpif_out_ch0_rdy_d),
        .o_stream_sel(o_stream_sel), .o_partial_sel(o_partial_sel), .o_zlp_sel(o_zlp_sel),
        .o_slcs_n(o_slcs_n), .o_slwr_n(o_slwr_n), .o_slrd_n(o_slrd_n), .o_sloe_n(o_sloe_n),
        .o_pktend_n(o_pktend_n), .o_fifo_addr(o_fifo_addr), .o_data(o_data),
        .o_data_oe(o_data_oe), .o_word_cnt(o_word_cnt), .o_pkt_cnt(o_pkt_cnt),
        .o_err_wr_not_rdy(o_err_wr_not_rdy)
    );

    // Directed vectors: partial-mode inputs with the expected pin view after the edge.
    typedef struct {
        logic [1:0]  req;
        logic        we_n;
        logic        pe_n;
        logic [31:0] d;
        logic        e_psel;
        logic        e_slwr;
        logic        e_pe;
        logic [31:0] e_data;
        logic        e_slcs;
        logic [31:0] e_wc;
        logic [15:0] e_pc;
    } vec_t;

    vec_t tbl [7];

    // Reference model: a mode phase with a remaining-drain countdown, plus the
    // expected value of every output after the coming edge.
    int          m_phase;   // 0 idle, 1 granted mode, 2 draining
    int          m_mode;
    int          m_left;
    logic [2:0]  e_sel;
    logic        e_rin, e_rout, e_slcs, e_slwr, e_pe, e_oe, e_err;
    logic [31:0] e_data, e_wc;
    logic [15:0] e_pc;

    task automatic model_reset();
        m_phase = 0; m_mode = 0; m_left = 0;
        e_sel = 3'b000; e_rin = 0; e_rout = 0; e_slcs = 1; e_slwr = 1; e_pe = 1;
        e_oe = 0; e_err = 0; e_data = 0; e_wc = 0; e_pc = 0;
    endtask

    task automatic model_step();
        bit on;
        on = (m_phase == 1);
        // statistics use the pin values currently on the outputs
        if (i_clr_stats) begin
            e_wc = 0; e_pc = 0; e_err = 0;
        end else begin
            if (e_slwr == 0) e_wc = e_wc + 1;
            if (e_pe == 0)   e_pc = e_pc + 1;
            if (e_slwr == 0 && e_rin == 0) e_err = 1;
        end
        e_rin  = i_flaga;
        e_rout = i_flagb;
        e_sel  = (on && int'(i_mode_req) == m_mode) ? 3'(1 << (m_mode - 1)) : 3'b000;
        e_slcs = !on;
        e_oe   = on;
        if (on) begin
            if (m_mode == 1)      begin e_slwr = i_we_n_stream;  e_pe = i_pkt_end_n_stream;  e_data = i_data_stream;  end
            else if (m_mode == 2) begin e_slwr = i_we_n_partial; e_pe = i_pkt_end_n_partial; e_data = i_data_partial; end
            else                  begin e_slwr = i_we_n_zlp;     e_pe = i_pkt_end_n_zlp;     e_data = 0;              end
        end else begin
            e_slwr = 1; e_pe = 1;
        end
        if (m_phase == 0) begin
            if (i_mode_req != 0) begin m_phase = 1; m_mode = int'(i_mode_req); end
        end else if (m_phase == 1) begin
            if (int'(i_mode_req) != m_mode) begin m_phase = 2; m_left = GUARD; end
        end else begin
            if (m_left == 1) m_phase = 0;
            else m_left = m_left - 1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_mode_req = 0; i_flaga = 1; i_flagb = 1;
        i_we_n_stream = 1; i_we_n_partial = 1; i_we_n_zlp = 1;
        i_pkt_end_n_stream = 1; i_pkt_end_n_partial = 1; i_pkt_end_n_zlp = 1;
        i_data_stream = 0; i_data_partial = 0; i_clr_stats = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_100);
        rst_n = 0;
        @(negedge clk_100);
        rst_n = 1;
    endtask

    logic [127:0] act_v, exp_v;

    initial begin
        rst_n = 0;
        idle_inputs();
        tbl[0] = '{2'd2, 1, 1, 32'hA0, 0, 1, 1, 32'h0,  1, 32'd0, 16'd0};
        tbl[1] = '{2'd2, 0, 1, 32'hA1, 1, 0, 1, 32'hA1, 0, 32'd0, 16'd0};
        tbl[2] = '{2'd2, 0, 1, 32'hA2, 1, 0, 1, 32'hA2, 0, 32'd1, 16'd0};
        tbl[3] = '{2'd2, 1, 0, 32'hA3, 1, 1, 0, 32'hA3, 0, 32'd2, 16'd0};
        tbl[4] = '{2'd2, 1, 1, 32'hA4, 1, 1, 1, 32'hA4, 0, 32'd2, 16'd1};
        tbl[5] = '{2'd1, 0, 1, 32'hA5, 0, 0, 1, 32'hA5, 0, 32'd2, 16'd1};
        tbl[6] = '{2'd1, 0, 1, 32'hA6, 0, 1, 1, 32'hA5, 1, 32'd3, 16'd1};

        #12;
        // reset values while held in reset
        chk("reset_pins", {o_slcs_n, o_slwr_n, o_slrd_n, o_sloe_n, o_pktend_n, o_data_oe, o_fifo_addr},
            {6'b111110, 2'b00});
        chk("reset_state", {o_stream_sel, o_partial_sel, o_zlp_sel, o_gpif_in_ch0_rdy_d,
            o_gpif_out_ch0_rdy_d, o_err_wr_not_rdy, o_data, o_word_cnt, o_pkt_cnt}, 64'd0);
        @(negedge clk_100);
        rst_n = 1;

        // stray generators write constantly; only the granted one may reach the pins
        i_we_n_stream = 0; i_data_stream = 32'hDEADBEEF; i_we_n_zlp = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_100);
            i_mode_req = tbl[i].req; i_we_n_partial = tbl[i].we_n;
            i_pkt_end_n_partial = tbl[i].pe_n; i_data_partial = tbl[i].d;
            @(posedge clk_100); #1;
            chk($sformatf("vec%0d", i),
                {o_partial_sel, o_slwr_n, o_pktend_n, o_slcs_n, o_data, o_word_cnt[15:0], o_pkt_cnt},
                {tbl[i].e_psel, tbl[i].e_slwr, tbl[i].e_pe, tbl[i].e_slcs, tbl[i].e_data,
                 tbl[i].e_wc[15:0], tbl[i].e_pc});
            chk($sformatf("vec%0d_other_sel", i), {o_stream_sel, o_zlp_sel}, 2'b00);
        end

        // drain: one edge already taken in DRAIN; guard + idle + activate = 18 edges to grant
        for (int k = 2; k <= 18; k++) begin
            @(posedge clk_100); #1;
            if (k < 18) chk($sformatf("drain_quiet%0d", k), {o_stream_sel, o_slwr_n, o_data}, {2'b01, 32'hA5});
            else        chk("drain_grant", {o_stream_sel, o_slwr_n, o_data}, {2'b10, 32'hDEADBEEF});
        end

        // write while FX3 not ready sets the sticky error
        @(negedge clk_100); i_flaga = 0;
        @(posedge clk_100); #1;
        chk("rdy_d_low", o_gpif_in_ch0_rdy_d, 0);
        @(posedge clk_100); #1;
        chk("err_set", o_err_wr_not_rdy, 1);
        @(negedge clk_100); i_flaga = 1;
        repeat (3) @(posedge clk_100);
        #1 chk("err_sticky", o_err_wr_not_rdy, 1);
        @(negedge clk_100); i_clr_stats = 1; i_pkt_end_n_stream = 0;
        @(posedge clk_100); #1;
        chk("clr_priority", {o_err_wr_not_rdy, o_word_cnt, o_pkt_cnt}, 49'd0);
        @(negedge clk_100); i_clr_stats = 0; i_pkt_end_n_stream = 1;
        @(posedge clk_100); #1;
        chk("count_after_clr", {o_word_cnt, o_pkt_cnt}, {32'd1, 16'd1});

        // asynchronous reset mid-transfer
        @(posedge clk_100); #2;
        rst_n = 0; #1;
        chk("async_rst", {o_slcs_n, o_slwr_n, o_pktend_n, o_data_oe, o_stream_sel, o_data, o_word_cnt},
            {4'b1110, 1'b0, 32'd0, 32'd0});
        @(negedge clk_100); idle_inputs(); rst_n = 1;
        repeat (3) begin
            @(posedge clk_100); #1;
            chk("post_rst_idle", {o_stream_sel, o_partial_sel, o_zlp_sel, o_slcs_n}, 4'b0001);
        end

        // random traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_100);
            if ($urandom_range(15) == 0) i_mode_req = 2'($urandom_range(3));
            i_flaga = ($urandom_range(7) != 0);
            i_flagb = 1'($urandom);
            i_we_n_stream = 1'($urandom);  i_pkt_end_n_stream  = ($urandom_range(7) != 0);
            i_we_n_partial = 1'($urandom); i_pkt_end_n_partial = ($urandom_range(7) != 0);
            i_we_n_zlp = 1'($urandom);     i_pkt_end_n_zlp     = ($urandom_range(7) != 0);
            i_data_stream = $urandom; i_data_partial = $urandom;
            i_clr_stats = ($urandom_range(63) == 0);
            model_step();
            @(posedge clk_100); #1;
            act_v = {o_zlp_sel, o_partial_sel, o_stream_sel, o_gpif_in_ch0_rdy_d, o_gpif_out_ch0_rdy_d,
                     o_slcs_n, o_slwr_n, o_pktend_n, o_data_oe, o_err_wr_not_rdy, o_data, o_word_cnt, o_pkt_cnt};
            exp_v = {e_sel, e_rin, e_rout, e_slcs, e_slwr, e_pe, e_oe, e_err, e_data, e_wc, e_pc};
            vectors++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL rand%0d: got %h expected %h", c, act_v, exp_v);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
